// File: rtl/byte_striper_n.sv
// Round-robin byte striper for the phy_tx lane serialisers.
// Collects NUM_LANES bytes, presents each stripe on all lanes together; flush pads partial stripes.
module byte_striper_n #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W = 8,
  parameter logic [DATA_W-1:0] PAD_WORD = 8'hBC,
  localparam int unsigned PTR_W = $clog2(NUM_LANES)
) (
  input  logic                        clk_2f,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        valid_in,
  input  logic                        flush,
  output logic [NUM_LANES*DATA_W-1:0] lane_data_out,
  output logic [NUM_LANES-1:0]        lane_valid_out,
  output logic                        stripe_out,
  output logic [PTR_W-1:0]            fill_ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_LANES - 1);

  logic [NUM_LANES-1:0][DATA_W-1:0] stripe_buf;
  logic [NUM_LANES-1:0]             bv;

  logic [NUM_LANES-1:0][DATA_W-1:0] nbuf;
  logic [NUM_LANES-1:0]             nbv;
  logic [NUM_LANES*DATA_W-1:0]      stripe_w;
  logic                             emit;

  // Buffer image with this cycle's byte written, padded lane image, emit decision.
  always_comb begin
    nbuf = stripe_buf;
    nbv  = bv;
    if (valid_in) begin
      nbuf[fill_ptr] = data_in;
      nbv[fill_ptr]  = 1'b1;
    end
    emit = (valid_in && fill_ptr == LAST) ||
           (flush && (fill_ptr != '0 || valid_in));
    for (int k = 0; k < NUM_LANES; k++) begin
      stripe_w[k*DATA_W +: DATA_W] = nbv[k] ? nbuf[k] : PAD_WORD;
    end
  end

  // Collect bytes, present completed or flushed stripes, hold outputs otherwise.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      stripe_buf     <= '0;
      bv             <= '0;
      fill_ptr       <= '0;
      lane_data_out  <= '0;
      lane_valid_out <= '0;
      stripe_out     <= 1'b0;
    end else begin
      stripe_out <= 1'b0;
      if (emit) begin
        lane_data_out  <= stripe_w;
        lane_valid_out <= nbv;
        stripe_out     <= 1'b1;
        fill_ptr       <= '0;
        bv             <= '0;
      end else if (valid_in) begin
        stripe_buf <= nbuf;
        bv         <= nbv;
        fill_ptr   <= fill_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_striper_n.sv
// Directed bench for byte_striper_n, 4 lanes x 8 bits.
// Expected stripes are queued at drive time and popped when stripe_out fires.
module tb_byte_striper_n;

  logic        clk_2f = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] lane_data_out;
  logic [3:0]  lane_valid_out;
  logic        stripe_out;
  logic [1:0]  fill_ptr;

  int vectors = 0;
  int errs = 0;
  logic [31:0] sb_d[$];
  logic [3:0]  sb_v[$];
  logic [31:0] last_d = '0;
  logic [3:0]  last_v = '0;

  byte_striper_n #(.NUM_LANES(4), .DATA_W(8), .PAD_WORD(8'hBC)) dut (
    .clk_2f(clk_2f),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .flush(flush),
    .lane_data_out(lane_data_out),
    .lane_valid_out(lane_valid_out),
    .stripe_out(stripe_out),
    .fill_ptr(fill_ptr)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] v);
    sb_d.push_back(d);
    sb_v.push_back(v);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic f,
                     input logic est, input logic [1:0] eptr);
    valid_in = v;
    data_in  = d;
    flush    = f;
    @(posedge clk_2f);
    #1;
    chk("stripe_out", {31'd0, stripe_out}, {31'd0, est});
    chk("fill_ptr", {30'd0, fill_ptr}, {30'd0, eptr});
    if (stripe_out && sb_d.size() > 0) begin
      last_d = sb_d.pop_front();
      last_v = sb_v.pop_front();
      chk("lane_data", lane_data_out, last_d);
      chk("lane_valid", {28'd0, lane_valid_out}, {28'd0, last_v});
    end else if (stripe_out) begin
      chk("sb_underflow", {31'd0, stripe_out}, 32'd0);
    end else begin
      chk("hold_data", lane_data_out, last_d);
      chk("hold_valid", {28'd0, lane_valid_out}, {28'd0, last_v});
    end
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic sb_drained(input string tag);
    chk(tag, sb_d.size(), 32'd0);
  endtask

  initial begin
    // 1: async reset between edges, then idle
    #3 reset = 1'b1;
    #1;
    chk("rst_data", lane_data_out, 32'd0);
    chk("rst_valid", {28'd0, lane_valid_out}, 32'd0);
    chk("rst_stripe", {31'd0, stripe_out}, 32'd0);
    chk("rst_ptr", {30'd0, fill_ptr}, 32'd0);
    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f);
    reset = 1'b0;
    repeat (8) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);

    // 2: four consecutive bytes
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 2'd3);
    push(32'h44332211, 4'b1111);
    cyc(1'b1, 8'h44, 1'b0, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    sb_drained("sb_t2");

    // 3: same bytes with valid gaps
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 2'd1);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 2'd2);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 2'd2);
    cyc(1'b0, 8'hEE, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 2'd3);
    push(32'h44332211, 4'b1111);
    cyc(1'b1, 8'h44, 1'b0, 1'b1, 2'd0);
    sb_drained("sb_t3");

    // 4: flush of a 2-byte partial, then flush on empty buffer
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0, 2'd2);
    push(32'hBCBCA2A1, 4'b0011);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    sb_drained("sb_t4");

    // 5: flush with a byte, and flush on the fourth byte
    cyc(1'b1, 8'hC1, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0, 2'd2);
    push(32'hBCC3C2C1, 4'b0111);
    cyc(1'b1, 8'hC3, 1'b1, 1'b1, 2'd0);
    cyc(1'b1, 8'hD1, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'hD2, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 8'hD3, 1'b0, 1'b0, 2'd3);
    push(32'hD4D3D2D1, 4'b1111);
    cyc(1'b1, 8'hD4, 1'b1, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
    sb_drained("sb_t5");

    // 6: twelve back-to-back bytes, then reset mid-stripe
    push(32'h04030201, 4'b1111);
    push(32'h08070605, 4'b1111);
    push(32'h0C0B0A09, 4'b1111);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 8'(i), 1'b0, (i % 4) == 0, 2'(i % 4));
    end
    cyc(1'b1, 8'h0D, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'h0E, 1'b0, 1'b0, 2'd2);
    sb_drained("sb_t6");
    #2 reset = 1'b1;
    #1;
    chk("rst2_data", lane_data_out, 32'd0);
    chk("rst2_valid", {28'd0, lane_valid_out}, 32'd0);
    chk("rst2_ptr", {30'd0, fill_ptr}, 32'd0);
    last_d = '0;
    last_v = '0;
    @(posedge clk_2f);
    @(negedge clk_2f);
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0);
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    push(32'hBCBCBC55, 4'b0001);
    cyc(1'b1, 8'h55, 1'b1, 1'b1, 2'd0);
    sb_drained("sb_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
